// File: rtl/rec_fp_unpack.sv
// Converts a HardFloat 65-bit recoded FP value to its raw IEEE-754 64-bit pattern (singles NaN-boxed).
// One-cycle registered latency; no backpressure, an input is accepted every cycle.
module rec_fp_unpack #(
    parameter int rec_width_p = 65,
    parameter int raw_width_p = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [rec_width_p-1:0] rec_i,
    input  logic                   sp_not_dp_i,
    output logic                   v_o,
    output logic [raw_width_p-1:0] raw_o
);

    logic               s;
    logic [11:0]        x;
    logic [51:0]        f;
    logic [22:0]        g;
    logic signed [12:0] e;
    logic signed [12:0] dp_sh;
    logic signed [12:0] sp_sh;
    logic [10:0]        dp_exp;
    logic [7:0]         sp_exp;
    logic [51:0]        dp_den;
    logic [22:0]        sp_den;
    logic               is_zero;
    logic               is_special;
    logic               is_nan;
    logic [31:0]        sp;
    logic [63:0]        raw_n;

    always_comb begin
        s          = rec_i[64];
        x          = rec_i[63:52];
        f          = rec_i[51:0];
        g          = rec_i[51:29];
        e          = $signed({1'b0, x}) - 13'sd2048;
        is_zero    = (x[11:9] == 3'b000);
        is_special = (x[11:10] == 2'b11);
        is_nan     = is_special && x[9];

        // Shift distances are only consulted when e lies in the subnormal window,
        // where they are known positive and in range.
        dp_sh  = -13'sd1022 - e;
        sp_sh  = -13'sd126 - e;
        dp_exp = 11'(e + 13'sd1023);
        sp_exp = 8'(e + 13'sd127);
        dp_den = 52'({1'b1, f} >> dp_sh);
        sp_den = 23'({1'b1, g} >> sp_sh);

        sp = {s, 31'h0};
        if (is_zero)
            sp = {s, 31'h0};
        else if (is_special)
            sp = is_nan ? {s, 8'hFF, g} : {s, 8'hFF, 23'h0};
        else if (e > 13'sd127)
            sp = {s, 8'hFF, 23'h0};
        else if (e >= -13'sd126)
            sp = {s, sp_exp, g};
        else if (e >= -13'sd149)
            sp = {s, 8'h00, sp_den};
        else
            sp = {s, 31'h0};

        raw_n = {s, 63'h0};
        if (sp_not_dp_i)
            raw_n = {32'hFFFF_FFFF, sp};
        else if (is_zero)
            raw_n = {s, 63'h0};
        else if (is_special)
            raw_n = is_nan ? {s, 11'h7FF, f} : {s, 11'h7FF, 52'h0};
        else if (e > 13'sd1023)
            raw_n = {s, 11'h7FF, 52'h0};
        else if (e >= -13'sd1022)
            raw_n = {s, dp_exp, f};
        else if (e >= -13'sd1074)
            raw_n = {s, 11'h000, dp_den};
        else
            raw_n = {s, 63'h0};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_o   <= 1'b0;
            raw_o <= '0;
        end else begin
            v_o <= v_i;
            if (v_i)
                raw_o <= raw_n;
        end
    end

endmodule

// File: tb/tb_rec_fp_unpack.sv
// Directed-vector bench for rec_fp_unpack: reset, specials, subnormals, throughput and hold.
module tb_rec_fp_unpack;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [64:0] rec_i;
    logic        sp_not_dp_i;
    logic        v_o;
    logic [63:0] raw_o;

    int errors = 0;
    int checks = 0;

    localparam int NV = 19;
    logic [64:0] vec_rec [NV];
    logic        vec_sp  [NV];
    logic [63:0] vec_exp [NV];

    rec_fp_unpack dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .rec_i       (rec_i),
        .sp_not_dp_i (sp_not_dp_i),
        .v_o         (v_o),
        .raw_o       (raw_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic s, input logic [11:0] x, input logic [51:0] f,
                           input logic sp, input logic [63:0] exp);
        vec_rec[i] = {s, x, f};
        vec_sp[i]  = sp;
        vec_exp[i] = exp;
    endtask

    initial begin
        set_vec(0,  1'b0, 12'h800, 52'h0,             1'b0, 64'h3FF0000000000000); // DP 1.0
        set_vec(1,  1'b0, 12'h800, 52'h0,             1'b1, 64'hFFFFFFFF3F800000); // SP 1.0
        set_vec(2,  1'b1, 12'hC00, 52'h0,             1'b1, 64'hFFFFFFFFFF800000); // SP -inf
        set_vec(3,  1'b1, 12'h000, 52'h0,             1'b0, 64'h8000000000000000); // DP -0
        set_vec(4,  1'b0, 12'hE00, 52'h8000000000000, 1'b0, 64'h7FF8000000000000); // DP NaN
        set_vec(5,  1'b0, 12'h3CE, 52'h0,             1'b0, 64'h0000000000000001); // DP min denormal
        set_vec(6,  1'b0, 12'h76B, 52'h0,             1'b1, 64'hFFFFFFFF00000001); // SP min denormal
        set_vec(7,  1'b1, 12'h3CD, 52'h0,             1'b0, 64'h8000000000000000); // DP underflow
        set_vec(8,  1'b0, 12'hE00, 52'h8000000000001, 1'b1, 64'hFFFFFFFF7FC00000); // SP NaN
        set_vec(9,  1'b0, 12'hBFF, 52'hFFFFFFFFFFFFF, 1'b0, 64'h7FEFFFFFFFFFFFFF); // DP max
        set_vec(10, 1'b0, 12'h880, 52'h0,             1'b1, 64'hFFFFFFFF7F800000); // SP overflow
        set_vec(11, 1'b0, 12'h87F, 52'hFFFFFFFFFFFFF, 1'b1, 64'hFFFFFFFF7F7FFFFF); // SP max
        set_vec(12, 1'b0, 12'h402, 52'h0,             1'b0, 64'h0010000000000000); // DP min normal
        set_vec(13, 1'b0, 12'h401, 52'h0,             1'b0, 64'h0008000000000000); // DP subnormal
        set_vec(14, 1'b0, 12'h781, 52'h0,             1'b1, 64'hFFFFFFFF00400000); // SP subnormal
        set_vec(15, 1'b1, 12'h76A, 52'h0,             1'b1, 64'hFFFFFFFF80000000); // SP underflow
        set_vec(16, 1'b0, 12'hC00, 52'h123,           1'b0, 64'h7FF0000000000000); // DP +inf
        set_vec(17, 1'b0, 12'h800, 52'h8000000000000, 1'b0, 64'h3FF8000000000000); // DP 1.5
        set_vec(18, 1'b0, 12'h1FF, 52'h0,             1'b1, 64'hFFFFFFFF00000000); // SP +0

        reset_i     = 1'b1;
        v_i         = 1'b0;
        rec_i       = '0;
        sp_not_dp_i = 1'b0;
        #1;
        chk("reset_v", {63'h0, v_o}, 64'h0);
        chk("reset_raw", raw_o, 64'h0);

        @(negedge clk_i);
        reset_i     = 1'b0;
        v_i         = 1'b1;
        rec_i       = vec_rec[0];
        sp_not_dp_i = vec_sp[0];
        @(negedge clk_i);
        chk("first_v", {63'h0, v_o}, 64'h1);
        chk("first_dp1", raw_o, vec_exp[0]);

        // Asynchronous reset while v_o is high, observed before the next edge.
        #1 reset_i = 1'b1;
        #1;
        chk("async_rst_v", {63'h0, v_o}, 64'h0);
        chk("async_rst_raw", raw_o, 64'h0);
        @(negedge clk_i);
        chk("rst_held_v", {63'h0, v_o}, 64'h0);
        chk("rst_held_raw", raw_o, 64'h0);
        reset_i = 1'b0;

        // Back-to-back stream; each result checked one cycle after it was driven.
        for (int i = 0; i < NV; i++) begin
            if (i > 0) begin
                @(negedge clk_i);
                chk($sformatf("vec%0d_v", i - 1), {63'h0, v_o}, 64'h1);
                chk($sformatf("vec%0d_raw", i - 1), raw_o, vec_exp[i - 1]);
            end
            v_i         = 1'b1;
            rec_i       = vec_rec[i];
            sp_not_dp_i = vec_sp[i];
        end
        @(negedge clk_i);
        chk($sformatf("vec%0d_v", NV - 1), {63'h0, v_o}, 64'h1);
        chk($sformatf("vec%0d_raw", NV - 1), raw_o, vec_exp[NV - 1]);

        // Idle input must not disturb the held result.
        v_i         = 1'b0;
        rec_i       = vec_rec[0];
        sp_not_dp_i = 1'b0;
        @(negedge clk_i);
        chk("hold1_v", {63'h0, v_o}, 64'h0);
        chk("hold1_raw", raw_o, vec_exp[NV - 1]);
        rec_i = vec_rec[9];
        @(negedge clk_i);
        chk("hold2_v", {63'h0, v_o}, 64'h0);
        chk("hold2_raw", raw_o, vec_exp[NV - 1]);

        v_i   = 1'b1;
        rec_i = vec_rec[9];
        @(negedge clk_i);
        v_i = 1'b0;
        chk("resume_v", {63'h0, v_o}, 64'h1);
        chk("resume_raw", raw_o, vec_exp[9]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
